aes_test_sequencer: RTL and testbench
=====================================

Name: aes_test_sequencer

Overview:
- Verification-platform controller that sequences the AES-128 chip under test through a vector memory of (key, plaintext, expected ciphertext) triples.
- For each vector it fetches, loads and starts the chip, waits for completion with a timeout, compares the result and issues one result pulse to the scoreboard.
- Sits between the vector memory, the chip wrapper and the scoreboard, which accumulates total and correct counts from the result pulses.

Parameters:
- NUM_VEC, 16, number of vectors per run (1..2^ADDR_W).
- ADDR_W, 4, vector memory address width.
- TIMEOUT, 64, maximum WAIT cycles before a vector is declared failed (>=2).
- TO_W, 7, timeout counter width (must hold TIMEOUT).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  single-cycle start request; sampled only in IDLE
- abort  in  1  stop the run after the current state; go to IDLE
- vec_addr  out  ADDR_W  vector memory read address
- vec_key  in  128  key at vec_addr; 1-cycle read latency
- vec_pt  in  128  plaintext at vec_addr; 1-cycle read latency
- vec_ct  in  128  expected ciphertext at vec_addr; 1-cycle read latency
- chip_start  out  1  one-cycle start pulse to the chip
- chip_key  out  128  registered key to the chip
- chip_din  out  128  registered plaintext to the chip
- chip_done  in  1  chip completion pulse
- chip_dout  in  128  chip ciphertext; valid while chip_done=1
- res_valid  out  1  one-cycle result pulse to the scoreboard
- res_pass  out  1  1 = ciphertext matched; qualified by res_valid
- res_timeout  out  1  1 = vector timed out; qualified by res_valid
- res_idx  out  ADDR_W  vector index of the current result
- busy  out  1  high in every state except IDLE
- run_done  out  1  one-cycle pulse when all NUM_VEC vectors are reported

Behaviour:
- Reset: all outputs 0, state IDLE, index 0, timeout counter 0.
- States: IDLE, FETCH, LOAD, START, WAIT, REPORT, FINISH.
- IDLE: run=1 -> FETCH; index=0.
- FETCH: vec_addr=index; -> LOAD.
- LOAD: capture vec_key/vec_pt into chip_key/chip_din and vec_ct into an internal expected register; -> START.
- START: chip_start=1 for exactly one cycle; clear timeout counter; -> WAIT.
- WAIT:
  - counter increments each cycle.
  - chip_done=1: capture the compare result (chip_dout==expected); -> REPORT.
  - Else, counter==TIMEOUT-1: flag timeout; -> REPORT.
  - chip_done and timeout expiry in the same cycle: done wins, so the result is a real compare.
- REPORT:
  - res_valid=1 for one cycle, with res_idx=index.
  - Match: res_pass=1, res_timeout=0.
  - Mismatch: res_pass=0, res_timeout=0.
  - Timeout: res_pass=0, res_timeout=1.
  - index==NUM_VEC-1 -> FINISH; else increment index -> FETCH.
- FINISH: run_done=1 for one cycle; -> IDLE.
- Latency: run sampled at cycle 0 -> FETCH cycle 1, LOAD 2, START 3 (chip_start high), WAIT from cycle 4. chip_done at cycle d -> res_valid at d+1. Next FETCH at d+2.
- chip_done outside WAIT is ignored.
- run while busy=1 is ignored.
- Index wraps only via reset or a new run; it never exceeds NUM_VEC-1.
- abort=1 in any non-IDLE state -> IDLE next cycle, with no res_valid and no run_done. If abort and REPORT coincide, the REPORT pulse is still emitted this cycle.
- Reset mid-operation: immediate return to IDLE with all outputs 0; the chip must be re-run.
- chip_key/chip_din hold their values from LOAD until the next LOAD.

Decomposition:
- Shared package aes_vp_pkg: state encoding constants, the 128-bit block width, and default TIMEOUT.
- One natural sub-module, vp_timeout_cnt: loadable/clearable counter with terminal-count output.
- Compare and FSM stay in the top module.

Test Plan:
- NUM_VEC=2; FIPS-197 vector (key 000102..0f, pt 00112233..ff, ct 69c4e0d8..c55a) at both entries; chip model answers 10 cycles after start -> two res_valid pulses, res_pass=1, res_idx=0 then 1, then one run_done.
- Vector 1 ct corrupted by one bit -> idx0 pass; idx1 res_pass=0, res_timeout=0.
- Chip never asserts done, TIMEOUT=64 -> res_valid exactly 64 cycles after WAIT entry, res_timeout=1, then the sequence advances.
- chip_done on the final timeout cycle -> res_pass reflects the compare, res_timeout=0.
- abort asserted during WAIT of idx0 -> IDLE next cycle, busy=0, no res_valid, no run_done.
- Separately, rst_n pulsed mid-run -> all outputs 0 immediately; a later run restarts at idx0.
- run pulsed while busy -> ignored: result count stays NUM_VEC.
- chip_done injected while in IDLE -> no effect on any output.

Source files
------------

// File: rtl/aes_vp_pkg.sv
// Shared definitions for the AES-128 verification-platform sequencer.
//   BLK_W       : AES block / key width in bits
//   TIMEOUT_DEF : default number of WAIT cycles before a vector is failed
//   state_t     : sequencer state encoding
package aes_vp_pkg;

    localparam int BLK_W       = 128;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_REPORT = 3'd5,
        S_FINISH = 3'd6
    } state_t;

endpackage

// File: rtl/vp_timeout_cnt.sv
// Clearable up-counter with terminal-count flag, used to bound the wait
// for the chip's completion pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : count enable
//   cnt        : current count
//   tc         : high while cnt == TC-1
module vp_timeout_cnt #(
    parameter int W  = 7,
    parameter int TC = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == W'(TC - 1));

endmodule

// File: rtl/aes_test_sequencer.sv
// Walks the AES-128 chip under test through NUM_VEC (key, pt, ct) vectors:
// fetch, load, start, wait (with timeout), compare, report one result pulse.
//   clk, rst_n          : clock, asynchronous active-low reset
//   run, abort          : start a run (IDLE only) / drop back to IDLE
//   vec_addr            : vector memory address (1-cycle read latency)
//   vec_key/pt/ct       : vector memory read data
//   chip_start          : one-cycle start pulse to the chip
//   chip_key, chip_din  : registered key / plaintext to the chip
//   chip_done/dout      : chip completion pulse and ciphertext
//   res_valid/pass/timeout/idx : one result pulse per vector
//   busy, run_done      : activity flag and end-of-run pulse
module aes_test_sequencer
    import aes_vp_pkg::*;
#(
    parameter int NUM_VEC = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              abort,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [BLK_W-1:0]  vec_key,
    input  logic [BLK_W-1:0]  vec_pt,
    input  logic [BLK_W-1:0]  vec_ct,
    output logic              chip_start,
    output logic [BLK_W-1:0]  chip_key,
    output logic [BLK_W-1:0]  chip_din,
    input  logic              chip_done,
    input  logic [BLK_W-1:0]  chip_dout,
    output logic              res_valid,
    output logic              res_pass,
    output logic              res_timeout,
    output logic [ADDR_W-1:0] res_idx,
    output logic              busy,
    output logic              run_done
);

    state_t             state;
    logic [ADDR_W-1:0]  idx;
    logic [BLK_W-1:0]   exp_ct;
    logic [TO_W-1:0]    to_cnt;
    logic               to_tc;

    // The index register is the memory address during FETCH and the
    // reported index during REPORT; it only changes when leaving REPORT.
    assign vec_addr = idx;
    assign res_idx  = idx;

    vp_timeout_cnt #(
        .W  (TO_W),
        .TC (TIMEOUT)
    ) u_to (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == S_START),
        .en    (state == S_WAIT),
        .cnt   (to_cnt),
        .tc    (to_tc)
    );

    // Pulse outputs are set on the transition into the state that owns
    // them, so they are high exactly for that state's single cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            exp_ct      <= '0;
            chip_key    <= '0;
            chip_din    <= '0;
            chip_start  <= 1'b0;
            res_valid   <= 1'b0;
            res_pass    <= 1'b0;
            res_timeout <= 1'b0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
        end else begin
            chip_start  <= 1'b0;
            res_valid   <= 1'b0;
            res_pass    <= 1'b0;
            res_timeout <= 1'b0;
            run_done    <= 1'b0;
            if (abort && state != S_IDLE) begin
                // A REPORT pulse already on the outputs this cycle survives.
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (run) begin
                            state <= S_FETCH;
                            idx   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    S_FETCH: state <= S_LOAD;
                    S_LOAD: begin
                        chip_key   <= vec_key;
                        chip_din   <= vec_pt;
                        exp_ct     <= vec_ct;
                        chip_start <= 1'b1;
                        state      <= S_START;
                    end
                    S_START: state <= S_WAIT;
                    S_WAIT: begin
                        // done is checked first so a late answer on the
                        // last timeout cycle still gets a real compare
                        if (chip_done) begin
                            res_valid <= 1'b1;
                            res_pass  <= (chip_dout == exp_ct);
                            state     <= S_REPORT;
                        end else if (to_tc) begin
                            res_valid   <= 1'b1;
                            res_timeout <= 1'b1;
                            state       <= S_REPORT;
                        end
                    end
                    S_REPORT: begin
                        if (idx == ADDR_W'(NUM_VEC - 1)) begin
                            run_done <= 1'b1;
                            state    <= S_FINISH;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                    S_FINISH: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_test_sequencer.sv
// Directed bench for aes_test_sequencer with a two-entry vector memory,
// a latency-programmable chip model and a cycle-timeline reference model.
module tb_aes_test_sequencer;

    localparam int NV  = 2;
    localparam int AW  = 4;
    localparam int TO  = 64;
    localparam int TW  = 7;
    localparam int MAXC = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] vec_addr;
    logic [127:0]  vec_key, vec_pt, vec_ct;
    logic          chip_start;
    logic [127:0]  chip_key, chip_din;
    logic          chip_done;
    logic [127:0]  chip_dout;
    logic          res_valid, res_pass, res_timeout;
    logic [AW-1:0] res_idx;
    logic          busy, run_done;

    always #5 clk = ~clk;

    aes_test_sequencer #(
        .NUM_VEC (NV),
        .ADDR_W  (AW),
        .TIMEOUT (TO),
        .TO_W    (TW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .abort       (abort),
        .vec_addr    (vec_addr),
        .vec_key     (vec_key),
        .vec_pt      (vec_pt),
        .vec_ct      (vec_ct),
        .chip_start  (chip_start),
        .chip_key    (chip_key),
        .chip_din    (chip_din),
        .chip_done   (chip_done),
        .chip_dout   (chip_dout),
        .res_valid   (res_valid),
        .res_pass    (res_pass),
        .res_timeout (res_timeout),
        .res_idx     (res_idx),
        .busy        (busy),
        .run_done    (run_done)
    );

    // FIPS-197 appendix C.1 vector
    localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // vector memory, 1-cycle read latency
    logic [127:0] mkey [0:15];
    logic [127:0] mpt  [0:15];
    logic [127:0] mct  [0:15];
    always @(posedge clk) begin
        vec_key <= mkey[vec_addr];
        vec_pt  <= mpt[vec_addr];
        vec_ct  <= mct[vec_addr];
    end

    // chip model: the n-th start of a run answers lat_tbl[n] cycles later
    // (0 = never answers); always returns the correct FIPS ciphertext
    int   lat_tbl [0:1];
    logic chip_clr = 1'b0;
    logic inj_done = 1'b0;
    int   cd = 0;
    int   nstart = 0;
    always @(posedge clk) begin
        if (chip_clr) begin
            cd     <= 0;
            nstart <= 0;
        end else if (chip_start) begin
            cd     <= (nstart < 2) ? lat_tbl[nstart] : 0;
            nstart <= nstart + 1;
        end else if (cd > 0) begin
            cd <= cd - 1;
        end
    end
    assign chip_done = (cd == 1) || inj_done;
    assign chip_dout = FCT;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int cyc, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Expected timeline, cycle 1 = first cycle after run is sampled.
    bit e_rv [0:MAXC-1];
    bit e_pass [0:MAXC-1];
    bit e_to [0:MAXC-1];
    bit e_done [0:MAXC-1];
    bit e_busy [0:MAXC-1];
    bit e_start [0:MAXC-1];
    int e_idx [0:MAXC-1];

    // Per vector: FETCH at f, START at f+2, WAIT from f+3. An answer
    // lat cycles after START lands in WAIT if 1<=lat<=TO; result is then
    // reported the cycle after the answer, otherwise TO cycles after WAIT
    // entry. Next FETCH follows the report; FINISH follows the last one.
    task automatic build_model(input int abort_cyc);
        int f, s, w, r, lat;
        bit ans;
        for (int n = 0; n < MAXC; n++) begin
            e_rv[n] = 0; e_pass[n] = 0; e_to[n] = 0; e_done[n] = 0;
            e_busy[n] = 0; e_start[n] = 0; e_idx[n] = 0;
        end
        f = 1;
        for (int i = 0; i < NV; i++) begin
            s   = f + 2;
            w   = f + 3;
            lat = lat_tbl[i];
            ans = (lat >= 1 && lat <= TO);
            r   = ans ? s + lat + 1 : w + TO;
            e_start[s] = 1;
            e_idx[s]   = i;
            e_rv[r]    = 1;
            e_pass[r]  = ans && (mct[i] == FCT);
            e_to[r]    = !ans;
            e_idx[r]   = i;
            f = r + 1;
        end
        e_done[f] = 1;
        for (int n = 1; n <= f; n++) e_busy[n] = 1;
        if (abort_cyc > 0)
            for (int n = abort_cyc + 1; n < MAXC; n++) begin
                e_rv[n] = 0; e_done[n] = 0; e_busy[n] = 0; e_start[n] = 0;
            end
    endtask

    int first_rv;
    int nres;
    int ndone;

    // Launch one run and compare every cycle against the model.
    task automatic run_seq(input int ncyc, input int abort_cyc, input int rp0,
                           input int rp1, input int inj_cyc);
        build_model(abort_cyc);
        @(negedge clk); chip_clr = 1'b1;
        @(negedge clk); chip_clr = 1'b0; run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        first_rv = -1; nres = 0; ndone = 0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            chk("res_valid", n, res_valid, e_rv[n]);
            chk("run_done", n, run_done, e_done[n]);
            chk("busy", n, busy, e_busy[n]);
            chk("chip_start", n, chip_start, e_start[n]);
            if (e_rv[n]) begin
                chk("res_pass", n, res_pass, e_pass[n]);
                chk("res_timeout", n, res_timeout, e_to[n]);
                chk("res_idx", n, res_idx, e_idx[n]);
            end
            if (e_start[n]) begin
                chk("chip_key", n, chip_key, mkey[e_idx[n]]);
                chk("chip_din", n, chip_din, mpt[e_idx[n]]);
            end
            if (res_valid) begin
                nres++;
                if (first_rv < 0) first_rv = n;
            end
            if (run_done) ndone++;
            abort    = (n == abort_cyc);
            run      = (n == rp0 || n == rp1);
            inj_done = (n == inj_cyc);
        end
        abort = 1'b0; run = 1'b0; inj_done = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " busy"}, 0, busy, 0);
        chk({nm, " res_valid"}, 0, res_valid, 0);
        chk({nm, " res_pass"}, 0, res_pass, 0);
        chk({nm, " res_timeout"}, 0, res_timeout, 0);
        chk({nm, " run_done"}, 0, run_done, 0);
        chk({nm, " chip_start"}, 0, chip_start, 0);
        chk({nm, " chip_key"}, 0, chip_key, 0);
        chk({nm, " chip_din"}, 0, chip_din, 0);
        chk({nm, " vec_addr"}, 0, vec_addr, 0);
        chk({nm, " res_idx"}, 0, res_idx, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mkey[i] = '0; mpt[i] = '0; mct[i] = '0;
        end
        for (int i = 0; i < NV; i++) begin
            mkey[i] = FKEY; mpt[i] = FPT; mct[i] = FCT;
        end
        lat_tbl[0] = 10; lat_tbl[1] = 10;

        // reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post-reset");

        // chip_done while idle does nothing
        for (int n = 0; n < 3; n++) begin
            inj_done = 1'b1;
            @(negedge clk);
            chk("idle-done busy", n, busy, 0);
            chk("idle-done res_valid", n, res_valid, 0);
            chk("idle-done run_done", n, run_done, 0);
            chk("idle-done chip_start", n, chip_start, 0);
        end
        inj_done = 1'b0;

        // two passing vectors, answer 10 cycles after start
        run_seq(35, 0, 0, 0, 0);
        chk("t1 first result cycle", 0, first_rv, 14);
        chk("t1 result count", 0, nres, 2);
        chk("t1 run_done count", 0, ndone, 1);

        // run pulses while busy (mid-vector and during FINISH) are ignored
        run_seq(40, 0, 5, 29, 0);
        chk("t7 result count", 0, nres, 2);
        chk("t7 run_done count", 0, ndone, 1);

        // vector 1 expected ciphertext off by one bit -> mismatch
        mct[1] = FCT ^ 128'h1;
        run_seq(35, 0, 0, 0, 0);
        mct[1] = FCT;

        // vector 0 never answers -> timeout 64 cycles after WAIT entry
        lat_tbl[0] = 0;
        run_seq(90, 0, 0, 0, 0);
        chk("t3 timeout result cycle", 0, first_rv, 68);
        chk("t3 result count", 0, nres, 2);

        // answer on the last timeout cycle -> real compare
        lat_tbl[0] = 64;
        run_seq(90, 0, 0, 0, 0);
        chk("t4 late-answer result cycle", 0, first_rv, 68);
        lat_tbl[0] = 10;

        // abort during WAIT of vector 0; chip still answers later in IDLE
        run_seq(40, 8, 0, 0, 20);
        chk("t5 result count", 0, nres, 0);
        chk("t5 run_done count", 0, ndone, 0);

        // reset mid-run clears everything at once; next run restarts at 0
        @(negedge clk); chip_clr = 1'b1;
        @(negedge clk); chip_clr = 1'b0; run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid-run reset");
        @(negedge clk); rst_n = 1'b1;
        run_seq(35, 0, 0, 0, 0);
        chk("t6 first result cycle", 0, first_rv, 14);
        chk("t6 result count", 0, nres, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
